// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and widths for the cart/save SRAM arbiter.
// Contents: state_t (FSM states), port_t (requester select), bus widths.
package sram_arb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter/sequencer in front of the 128Kx16 SRAM
// controller. Holds off all grants while the controller zero-fills after
// reset, then runs one fixed-length slot per request (req/ack handshake).
//
// Ports:
//   clk, reset_n           system clock, synchronous active-low reset
//   a_* (GB core, high)    req/we/ub/lb/addr/wdata in, ack/rdata out
//   b_* (APF save bridge)  req/we/ub/lb/addr/wdata in, ack/rdata out
//   mem_ready              high once the init wait has completed
//   sram_we/ub/lb/addr/d   registered bus to the controller
//   sram_q                 read data from the controller
//
// Build option: define SRAM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise port A always wins a contest.
//
// state | meaning
// INIT  | waiting INIT_CYCLES for the controller clear pass
// IDLE  | ready; grant a pending request
// WRITE | write bus held one cycle
// READ  | read bus held RD_LAT cycles, sram_q captured on the last
// DONE  | ack pulse on the granted port
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int INIT_CYCLES = 131072,
  parameter int RD_LAT      = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_ub,
  input  logic              a_lb,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_ub,
  input  logic              b_lb,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_ready,
  output logic              sram_we,
  output logic              sram_ub,
  output logic              sram_lb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int SCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
  localparam logic [SCW-1:0] SLOT_LAST = SCW'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [ICW-1:0]    init_cnt_q, init_cnt_d;
  logic [SCW-1:0]    slot_cnt_q, slot_cnt_d;
  port_t             grant_q, grant_d;
  logic              mem_ready_q, mem_ready_d;
  logic              sram_we_q, sram_we_d;
  logic              sram_ub_q, sram_ub_d;
  logic              sram_lb_q, sram_lb_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_d_q, sram_d_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_wins;
  port_t             sel;
  logic              sel_we;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  port_t             last_q, last_d;
`endif

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    grant_d     = grant_q;
    mem_ready_d = mem_ready_q;
    sram_we_d   = sram_we_q;
    sram_ub_d   = sram_ub_q;
    sram_lb_d   = sram_lb_q;
    sram_addr_d = sram_addr_q;
    sram_d_d    = sram_d_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
    // On a contest, the port that was not granted last goes first.
    a_wins      = a_req && (!b_req || (last_q == PORT_B));
`else
    a_wins      = a_req;
`endif
    sel         = a_wins ? PORT_A : PORT_B;
    sel_we      = a_wins ? a_we : b_we;

    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + ICW'(1);
        if (init_cnt_q == INIT_LAST) begin
          state_d     = IDLE;
          mem_ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (a_req || b_req) begin
          grant_d     = sel;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          last_d      = sel;
`endif
          sram_we_d   = sel_we;
          // Reads always fetch the full word; lanes only qualify writes.
          sram_ub_d   = sel_we ? (a_wins ? a_ub : b_ub) : 1'b1;
          sram_lb_d   = sel_we ? (a_wins ? a_lb : b_lb) : 1'b1;
          sram_addr_d = a_wins ? a_addr : b_addr;
          sram_d_d    = a_wins ? a_wdata : b_wdata;
          slot_cnt_d  = '0;
          state_d     = sel_we ? WRITE : READ;
        end
      end
      WRITE: begin
        sram_we_d = 1'b0;
        a_ack_d   = (grant_q == PORT_A);
        b_ack_d   = (grant_q == PORT_B);
        state_d   = DONE;
      end
      READ: begin
        if (slot_cnt_q == SLOT_LAST) begin
          if (grant_q == PORT_A) a_rdata_d = sram_q;
          else                   b_rdata_d = sram_q;
          a_ack_d = (grant_q == PORT_A);
          b_ack_d = (grant_q == PORT_B);
          state_d = DONE;
        end else begin
          slot_cnt_d = slot_cnt_q + SCW'(1);
        end
      end
      DONE: begin
        sram_we_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      slot_cnt_q  <= '0;
      grant_q     <= PORT_A;
      mem_ready_q <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_ub_q   <= 1'b0;
      sram_lb_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_d_q    <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q      <= PORT_B;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      grant_q     <= grant_d;
      mem_ready_q <= mem_ready_d;
      sram_we_q   <= sram_we_d;
      sram_ub_q   <= sram_ub_d;
      sram_lb_q   <= sram_lb_d;
      sram_addr_q <= sram_addr_d;
      sram_d_q    <= sram_d_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_ready = mem_ready_q;
  assign sram_we   = sram_we_q;
  assign sram_ub   = sram_ub_q;
  assign sram_lb   = sram_lb_q;
  assign sram_addr = sram_addr_q;
  assign sram_d    = sram_d_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a behavioural
// SRAM controller model (zero-filled on reset) and an ack scoreboard.
module tb_sram_arbiter;

  localparam int INIT_CYCLES = 16;
  localparam int RD_LAT      = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, a_ub, a_lb;
  logic [16:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req, b_we, b_ub, b_lb;
  logic [16:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        mem_ready;
  logic        sram_we, sram_ub, sram_lb;
  logic [16:0] sram_addr;
  logic [15:0] sram_d;
  logic [15:0] sram_q;

  always #5 clk = ~clk;

  sram_arbiter #(.INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_ub(a_ub), .a_lb(a_lb),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_ub(b_ub), .b_lb(b_lb),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_ready(mem_ready),
    .sram_we(sram_we), .sram_ub(sram_ub), .sram_lb(sram_lb),
    .sram_addr(sram_addr), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Controller model: cleared while reset is held, byte-lane writes.
  logic [15:0] mem [0:131071];
  assign sram_q = mem[sram_addr];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 131072; i++) mem[i] <= 16'h0000;
    end else if (sram_we) begin
      if (sram_ub) mem[sram_addr][15:8] <= sram_d[15:8];
      if (sram_lb) mem[sram_addr][7:0]  <= sram_d[7:0];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        rd;
    logic [15:0] rdata;
  } sb_t;
  sb_t sb_q[$];

  task automatic sb_push(input logic port, input logic rd, input logic [15:0] rdata);
    sb_t e;
    e.port  = port;
    e.rd    = rd;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic port, input logic [15:0] data);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("unexpected_ack", 32'(port), 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      chk("ack_port", 32'(port), 32'(e.port));
      if (e.rd) chk("rdata", 32'(data), 32'(e.rdata));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (a_ack === 1'b1) sb_check(1'b0, a_rdata);
      if (b_ack === 1'b1) sb_check(1'b1, b_rdata);
    end
  end

  logic last_port;

  task automatic drive(input logic port, input logic we, input logic ub, input logic lb,
                       input logic [16:0] addr, input logic [15:0] wd);
    if (!port) begin
      a_we = we; a_ub = ub; a_lb = lb; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end else begin
      b_we = we; b_ub = ub; b_lb = lb; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end
  endtask

  // Issue one access with the arbiter in IDLE; checks the bus at T+1 and
  // the ack latency, then releases req and returns in the next IDLE cycle.
  task automatic access(input logic port, input logic we, input logic ub, input logic lb,
                        input logic [16:0] addr, input logic [15:0] wd, input logic [15:0] exp_rd);
    int n;
    sb_push(port, !we, exp_rd);
    drive(port, we, ub, lb, addr, wd);
    @(negedge clk);
    chk("bus_addr", 32'(sram_addr), 32'(addr));
    chk("bus_we", 32'(sram_we), 32'(we));
    chk("bus_ub", 32'(sram_ub), we ? 32'(ub) : 32'd1);
    chk("bus_lb", 32'(sram_lb), we ? 32'(lb) : 32'd1);
    if (we) chk("bus_d", 32'(sram_d), 32'(wd));
    n = 1;
    while (((port ? b_ack : a_ack) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(we ? "write_ack_latency" : "read_ack_latency", 32'(n), we ? 32'd2 : 32'(RD_LAT + 1));
    if (!port) a_req = 1'b0; else b_req = 1'b0;
    last_port = port;
    @(negedge clk);
  endtask

  // From reset release: mem_ready must rise after INIT_CYCLES edges with
  // no ack, then the pending A request acks after its normal latency.
  task automatic init_wait(input int exp_lat);
    int k;
    logic early_ack;
    k = 0;
    early_ack = 1'b0;
    while (mem_ready !== 1'b1 && k < 4 * INIT_CYCLES) begin
      @(negedge clk);
      k++;
      if (a_ack === 1'b1 && mem_ready !== 1'b1) early_ack = 1'b1;
    end
    chk("mem_ready_cycle", 32'(k), 32'(INIT_CYCLES));
    chk("no_ack_in_init", 32'(early_ack), 32'd0);
    k = 0;
    while (a_ack !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_ack_latency", 32'(k), 32'(exp_lat));
    a_req = 1'b0;
    last_port = 1'b0;
    @(negedge clk);
  endtask

  logic exp_first;
  int   acks, cyc;

  initial begin
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_ub = 0; a_lb = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_ub = 0; b_lb = 0; b_addr = '0; b_wdata = '0;
    last_port = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_acks", 32'({a_ack, b_ack}), 32'd0);
    chk("rst_bus_ctl", 32'({sram_we, sram_ub, sram_lb}), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_d", 32'(sram_d), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);

    // Init hold with a write pending from the moment of release.
    sb_push(1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 17'h00123, 16'hBEEF);
    reset_n = 1'b1;
    init_wait(2);

    access(1'b0, 1'b0, 1'b0, 1'b0, 17'h00123, 16'h0000, 16'hBEEF);
    chk("b_rdata_not_owner", 32'(b_rdata), 32'd0);

    // Byte lane: only the low byte lands over a cleared word.
    access(1'b1, 1'b1, 1'b0, 1'b1, 17'h00456, 16'h12AB, 16'h0000);
    access(1'b1, 1'b0, 1'b1, 1'b0, 17'h00456, 16'h0000, 16'h00AB);
    chk("a_rdata_hold", 32'(a_rdata), 32'hBEEF);

    // Contention: both held high for four slots.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_first = ~last_port;
    for (int i = 0; i < 4; i++) sb_push(exp_first ^ i[0], 1'b0, 16'h0000);
`else
    for (int i = 0; i < 4; i++) sb_push(1'b0, 1'b0, 16'h0000);
`endif
    drive(1'b0, 1'b1, 1'b1, 1'b1, 17'h00010, 16'h1111);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 17'h00020, 16'h2222);
    acks = 0;
    cyc  = 0;
    while (acks < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (a_ack === 1'b1) acks++;
      if (b_ack === 1'b1) acks++;
    end
    chk("contention_acks", 32'(acks), 32'd4);
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    chk("contention_drained", 32'(sb_q.size()), 32'd0);

    // Top word.
    access(1'b0, 1'b1, 1'b1, 1'b1, 17'h1FFFF, 16'h5A5A, 16'h0000);
    access(1'b0, 1'b0, 1'b1, 1'b1, 17'h1FFFF, 16'h0000, 16'h5A5A);

    // Reset in the middle of a read; the controller clears memory again.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 17'h00010, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_mem_ready", 32'(mem_ready), 32'd0);
    chk("midrst_no_ack", 32'(a_ack), 32'd0);
    chk("midrst_a_rdata", 32'(a_rdata), 32'd0);
    chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
    sb_push(1'b0, 1'b1, 16'h0000);
    reset_n = 1'b1;
    init_wait(RD_LAT + 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
